// File: rtl/clock_fnd_ctrl_if.sv
// Time/edit-state inputs from the timekeeping core and the FND pin outputs.
// The master side is the timekeeping core (or bench); the slave is the display controller.
interface clock_fnd_ctrl_if;
   logic       tick_i;
   logic [6:0] sec_i;
   logic [6:0] min_i;
   logic [6:0] hour_i;
   logic [6:0] centisec_i;
   logic [1:0] edit_state_i;
   logic       view_sel_i;
   logic [3:0] an_o;
   logic [7:0] seg_o;

   modport master (
      output tick_i, sec_i, min_i, hour_i, centisec_i, edit_state_i, view_sel_i,
      input  an_o, seg_o
   );

   modport slave (
      input  tick_i, sec_i, min_i, hour_i, centisec_i, edit_state_i, view_sel_i,
      output an_o, seg_o
   );
endinterface

// File: rtl/clock_fnd_ctrl.sv
// 4-digit common-anode 7-segment driver for the clock: BCD conversion, page select,
// frame-synchronous time snapshot and edit-field blinking.
module clock_fnd_ctrl #(
   parameter int unsigned SCAN_DIV    = 100000,
   parameter int unsigned BLINK_TICKS = 50
) (
   input  logic            clk,
   input  logic            rst_n,
   clock_fnd_ctrl_if.slave bus
);
   localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
   localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      EDIT_SEC  = 2'd1,
      EDIT_MIN  = 2'd2,
      EDIT_HOUR = 2'd3
   } edit_e;

   typedef struct packed {
      logic [6:0] sec;
      logic [6:0] min;
      logic [6:0] hour;
      logic [6:0] cs;
   } snap_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   edit_e             edit_w;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]        digit_q, digit_d;
   logic              scan_wrap_w;
   snap_t             snap_q, snap_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic              phase_on_q, phase_on_d;
   edit_e             prev_edit_q;
   logic [3:0]        an_q, an_d;
   logic [7:0]        seg_q, seg_d;

   logic              page_w;
   logic [6:0]        field_w;
   logic [3:0]        tens_w, ones_w;
   logic [6:0]        seg7_w;
   logic              dp_n_w;

   assign edit_w      = edit_e'(bus.edit_state_i);
   assign scan_wrap_w = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      scan_cnt_d = scan_wrap_w ? '0 : scan_cnt_q + 1'b1;
      digit_d    = scan_wrap_w ? digit_q + 2'd1 : digit_q;
      snap_d     = snap_q;
      if (scan_wrap_w && (digit_q == 2'd3)) begin
         snap_d = '{sec: bus.sec_i, min: bus.min_i, hour: bus.hour_i, cs: bus.centisec_i};
      end
   end

   // An edit-state change restarts the blink and outranks a coincident tick.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_on_d  = phase_on_q;
      if (edit_w != prev_edit_q) begin
         blink_cnt_d = '0;
         phase_on_d  = 1'b1;
      end else if (bus.tick_i) begin
         if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      case (edit_w)
         RUN:      page_w = bus.view_sel_i;
         EDIT_SEC: page_w = 1'b1;
         default:  page_w = 1'b0;
      endcase

      if (digit_q[1]) field_w = page_w ? snap_q.sec : snap_q.hour;
      else            field_w = page_w ? snap_q.cs  : snap_q.min;

      // Tens by threshold count; only meaningful for 0..99, larger values show a dash.
      tens_w = '0;
      for (int k = 1; k <= 9; k++) begin
         if (field_w >= 7'(10 * k)) tens_w = 4'(k);
      end
      ones_w = 4'(field_w - 7'(tens_w) * 7'd10);

      seg7_w = seg_encode(digit_q[0] ? tens_w : ones_w);
      if (field_w > 7'd99) begin
         seg7_w = 7'h3F;
      end else if (!page_w && (digit_q == 2'd3) && (tens_w == 4'd0)) begin
         seg7_w = 7'h7F;
      end
      if ((edit_w != RUN) && !phase_on_q && (digit_q[1] == (edit_w != EDIT_MIN))) begin
         seg7_w = 7'h7F;
      end

      dp_n_w = !((digit_q == 2'd3 - 2'd1) && ((edit_w != RUN) || phase_on_q));
      an_d   = ~(4'b0001 << digit_q);
      seg_d  = {dp_n_w, seg7_w};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q  <= '0;
         digit_q     <= 2'd0;
         snap_q      <= '0;
         blink_cnt_q <= '0;
         phase_on_q  <= 1'b1;
         prev_edit_q <= RUN;
         an_q        <= 4'hF;
         seg_q       <= 8'hFF;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         digit_q     <= digit_d;
         snap_q      <= snap_d;
         blink_cnt_q <= blink_cnt_d;
         phase_on_q  <= phase_on_d;
         prev_edit_q <= edit_w;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign bus.an_o  = an_q;
   assign bus.seg_o = seg_q;
endmodule

// File: tb/tb_clock_fnd_ctrl.sv
// Scoreboard bench for clock_fnd_ctrl: a cycle-count reference model predicts each
// registered display word; a negedge monitor compares it against the pins.
module tb_clock_fnd_ctrl;
   localparam int SCAN_DIV    = 4;
   localparam int BLINK_TICKS = 2;
   localparam int FRAME       = 4 * SCAN_DIV;

   logic clk = 1'b0;
   logic rst_n;

   clock_fnd_ctrl_if bus ();

   clock_fnd_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_TICKS(BLINK_TICKS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [7:0] seg;
      int         edge_n;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: position in the frame from the edge count, blink phase from
   // ticks since the last edit-state change, snapshot taken at each frame end.
   int         edge_n;
   int         ticks_k;
   logic [1:0] prev_edit_m;
   logic [6:0] m_sec, m_min, m_hour, m_cs;
   logic [7:0] code_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit phase_on_m();
      return ((ticks_k / BLINK_TICKS) % 2) == 0;
   endfunction

   function automatic logic [7:0] expect_seg(input int d);
      int         edit, page, v, dig;
      bit         edited;
      logic [7:0] g;
      edit = int'(bus.edit_state_i);
      page = (edit == 0) ? int'(bus.view_sel_i) : ((edit == 1) ? 1 : 0);
      if (d >= 2) v = page ? int'(m_sec) : int'(m_hour);
      else        v = page ? int'(m_cs)  : int'(m_min);
      if (v > 99) begin
         g = 8'hBF;
      end else begin
         dig = (d == 3 || d == 1) ? v / 10 : v % 10;
         g   = (d == 3 && page == 0 && dig == 0) ? 8'hFF : code_tab[dig];
      end
      edited = (edit == 2) ? (d < 2) : (d >= 2);
      if (edit != 0 && !phase_on_m() && edited) g = 8'hFF;
      if (d == 2 && (edit != 0 || phase_on_m())) g[7] = 1'b0;
      return g;
   endfunction

   task automatic reset_model();
      edge_n      = 0;
      ticks_k     = 0;
      prev_edit_m = 2'd0;
      m_sec       = '0;
      m_min       = '0;
      m_hour      = '0;
      m_cs        = '0;
   endtask

   // One clock: predict this edge's output from pre-edge model state, then advance the model.
   task automatic cycle();
      exp_t e;
      int   d;
      @(posedge clk);
      if (rst_n) begin
         edge_n++;
         d       = ((edge_n - 1) / SCAN_DIV) % 4;
         e.an    = 4'b1111;
         e.an[d] = 1'b0;
         e.seg   = expect_seg(d);
         e.edge_n = edge_n;
         sb_q.push_back(e);
         if (edge_n % FRAME == 0) begin
            m_sec  = bus.sec_i;
            m_min  = bus.min_i;
            m_hour = bus.hour_i;
            m_cs   = bus.centisec_i;
         end
         if (bus.edit_state_i != prev_edit_m) ticks_k = 0;
         else if (bus.tick_i)                  ticks_k++;
         prev_edit_m = bus.edit_state_i;
      end
      #2;
   endtask

   task automatic run(input int n, input int tick_period);
      for (int i = 0; i < n; i++) begin
         bus.tick_i = (tick_period > 0) && (i % tick_period == 0);
         cycle();
      end
      bus.tick_i = 1'b0;
   endtask

   task automatic set_time(input int h, input int m, input int s, input int c);
      bus.hour_i     = 7'(h);
      bus.min_i      = 7'(m);
      bus.sec_i      = 7'(s);
      bus.centisec_i = 7'(c);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("an@%0d", e.edge_n), {4'h0, bus.an_o}, {4'h0, e.an});
            check($sformatf("seg@%0d", e.edge_n), bus.seg_o, e.seg);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rst_n            = 1'b0;
      bus.tick_i       = 1'b0;
      bus.edit_state_i = 2'd0;
      bus.view_sel_i   = 1'b0;
      set_time(0, 0, 0, 0);
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check("reset_an", {4'h0, bus.an_o}, 8'h0F);
      check("reset_seg", bus.seg_o, 8'hFF);
      @(negedge clk);
      #1 rst_n = 1'b1;

      run(2 * FRAME, 0);

      set_time(12, 5, 0, 0);
      run(3 * FRAME, 3);

      bus.view_sel_i = 1'b1;
      set_time(12, 5, 7, 99);
      run(2 * FRAME, 3);
      bus.view_sel_i = 1'b0;

      bus.edit_state_i = 2'd1;
      run(4 * FRAME, 3);

      bus.edit_state_i = 2'd2;
      for (int i = 0; i < 60 && (phase_on_m() || i < 4); i++) begin
         bus.tick_i = (i % 3 == 0);
         cycle();
      end
      bus.edit_state_i = 2'd3;
      bus.tick_i       = 1'b1;
      cycle();
      run(3 * FRAME, 3);

      bus.edit_state_i = 2'd0;
      set_time(9, 100, 30, 45);
      run(2 * FRAME, 0);

      set_time(100, 59, 30, 45);
      run(FRAME, 0);
      for (int i = 0; i < FRAME && (edge_n % FRAME != 5); i++) cycle();
      bus.hour_i = 7'd23;
      run(2 * FRAME, 0);

      for (int i = 0; i < 7; i++) cycle();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midreset_an", {4'h0, bus.an_o}, 8'h0F);
      check("midreset_seg", bus.seg_o, 8'hFF);
      reset_model();
      sb_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("hold_reset_an", {4'h0, bus.an_o}, 8'h0F);
      @(negedge clk);
      #1 rst_n = 1'b1;
      run(2 * FRAME, 0);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) bus.edit_state_i = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) bus.view_sel_i   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            set_time($urandom_range(0, 127), $urandom_range(0, 127),
                     $urandom_range(0, 127), $urandom_range(0, 127));
         end
         bus.tick_i = ($urandom_range(0, 3) == 0);
         cycle();
      end
      bus.tick_i = 1'b0;

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/clock_fnd_ctrl.md
# clock_fnd_ctrl

Display-side consumer of the clock timekeeping core's time and edit-state outputs. Converts hour/minute/second/centisecond values to BCD and drives a 4-digit, common-anode, multiplexed 7-segment display. Selects the HH.MM or SS.CC page and blinks the field being edited. Sits between the timekeeping core and the board FND pins.

## Interface
- SCAN_DIV, 100000: iClk cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- BLINK_TICKS, 50: iTick pulses per blink half-period (0.5 s at 100 Hz).
- iClk  in  1  system clock; single clock domain.
- iRstn  in  1  reset, asynchronous and active-low.
- iTick  in  1  100 Hz single-cycle pulse, shared with the timekeeping core.
- iSec, iMin, iHour, iCentisec  in  7 each  time values, binary.
- iEditState  in  2  0 = RUN, 1 = EDIT_SEC, 2 = EDIT_MIN, 3 = EDIT_HOUR.
- iViewSel  in  1  page select in RUN only: 0 = HH.MM, 1 = SS.CC.
- oAn  out  4  digit enables, active-low; bit 0 is the rightmost digit.
- oSeg  out  8  segments, active-low; bits [6:0] = gfedcba, bit 7 = dp.

## Operation
- Reset values:
  - oAn = 4'b1111, oSeg = 8'hFF.
  - Scan counter = 0, digit index = 0.
  - Blink counter = 0, blink phase = ON.
  - All snapshot registers = 0. The previous edit state register = 0.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1, then wraps.
  - On a wrap, the digit index advances 0→1→2→3→0.
- Snapshot:
  - On a scan wrap with digit index = 3, latch iSec, iMin, iHour, iCentisec into the snapshot registers.
  - This prevents tearing within a frame. iEditState and iViewSel are used live.
- Page:
  - RUN: page = iViewSel.
  - EDIT_SEC: page = 1.
  - EDIT_MIN and EDIT_HOUR: page = 0.
- Fields:
  - Page 0: high = hour, low = minute.
  - Page 1: high = second, low = centisecond.
- Digit map:
  - Digit 3 = high tens.
  - Digit 2 = high ones, carries dp as the colon.
  - Digit 1 = low tens.
  - Digit 0 = low ones.
- BCD:
  - For values 0..99: tens = v/10, ones = v%10.
  - Values 100..127 display as a dash (8'hBF, dp excluded) in both digits of that field.
- Leading zero: on page 0 only, an hour tens digit of 0 is blanked (segments 7'h7F).
- Encoding (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99.
  - 5=92, 6=82, 7=F8, 8=80, 9=90.
- Blink timer:
  - Each iTick increments the blink counter.
  - At BLINK_TICKS-1 the counter wraps to 0 and the phase toggles.
  - If iEditState differs from its previous registered value, the counter is forced to 0 and the phase to ON. This takes priority over a coincident iTick.
- Edit blanking: in an EDIT state with phase OFF, blank segments [6:0] of the edited field.
  - SEC → digits 3 and 2.
  - MIN → digits 1 and 0.
  - HOUR → digits 3 and 2.
- Colon (dp, digit 2 only):
  - RUN: lit when phase = ON.
  - EDIT: always lit, including while digit 2 is blanked.
  - All other digits: dp off.

## Timing
- oAn and oSeg are registered.
- They reflect the digit index, snapshot, page and blink phase from one cycle earlier: 1-cycle latency.
- Exactly one oAn bit is low on every cycle after the first post-reset edge.
- The first post-reset edge drives digit 0 with snapshot zeros.
- A new snapshot is first visible in the digit-0 slot that follows the latch.
- Full frame = 4·SCAN_DIV cycles.
- A page change from iViewSel or iEditState takes effect on the next output register update, mid-frame if applicable.
- An edit-state change restarts the blink at ON on the same edge; blanking stops by the next output update.
- Asserting iRstn low mid-frame immediately forces the reset values; there is no partial frame after release.

## Test plan
- Reset, then release with SCAN_DIV=4 and all inputs 0:
  - oAn cycles 1110→1101→1011→0111, each for 4 cycles.
  - oSeg digit 0 = C0.
  - Page 0 digit 3 is blank (FF); digit 2 = 40 with the colon lit.
- RUN page 0 with hour=12, min=5:
  - After the snapshot, digits 3..0 = F9, 24/A4, C0, 92.
  - Digit 2 dp follows the blink phase.
  - Set iViewSel=1 with sec=7, cs=99: digits show C0, F8, 90, 90.
- BLINK_TICKS=2, iEditState=1, iTick every 3 cycles:
  - Phase toggles every 2 ticks.
  - While OFF, digits 3 and 2 are segment-blank; digit 2 dp stays lit (7F).
  - Digits 1 and 0 show the centiseconds.
- Switch iEditState 2→3 during the OFF phase:
  - Counter clears; phase is ON on the next output update.
  - A simultaneous iTick does not advance the counter.
- Apply iMin=100: digits 1 and 0 show BF.
- Change iHour mid-frame: the displayed hour stays unchanged until the frame wrap.
- Pull iRstn low mid-frame: oAn=1111 and oSeg=FF asynchronously; the scan restarts at digit 0.
